// File: rtl/xfer_offset_pkg.sv
// Shared types and constants for the byte-serial transfer-address offset adder.
package xfer_offset_pkg;

  typedef enum logic [1:0] {
    OP_INC   = 2'd0,
    OP_DEC   = 2'd1,
    OP_ADD_S = 2'd2,
    OP_ADD_U = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StDone
  } state_e;

  localparam logic [15:0] ResultRst = 16'h0000;

  // Widen the requested increment/offset to a full 16-bit operand B.
  function automatic logic [15:0] operand_b(op_e op, logic [7:0] main_bus);
    logic [15:0] b;
    b = 16'h0001;
    unique case (op)
      OP_INC:   b = 16'h0001;
      OP_DEC:   b = 16'hFFFF;
      OP_ADD_S: b = {{8{main_bus[7]}}, main_bus};
      OP_ADD_U: b = {8'h00, main_bus};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/xfer_offset_adder_if.sv
// Control/status bundle between the transfer register logic and the offset adder.
interface xfer_offset_adder_if;
  import xfer_offset_pkg::*;

  logic [15:0] Addr;
  logic [7:0]  MainBus;
  logic        start_n;
  op_e         op;
  logic        a_ta_xfer_n;
  logic        busy;
  logic        done;
  logic        carry;

  modport master (
    output Addr, MainBus, start_n, op, a_ta_xfer_n,
    input  busy, done, carry
  );

  modport slave (
    input  Addr, MainBus, start_n, op, a_ta_xfer_n,
    output busy, done, carry
  );
endinterface

// File: rtl/byte_adder.sv
// 8-bit adder slice with carry in/out, shared between the low and high byte steps.
module byte_adder (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       ci_i,
  output logic [7:0] sum_o,
  output logic       co_o
);
  assign {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {8'h00, ci_i};
endmodule

// File: rtl/xfer_offset_adder.sv
// Two-cycle byte-serial 16-bit address adder; result is driven back on the transfer bus.
module xfer_offset_adder
  import xfer_offset_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  xfer_offset_adder_if.slave bus_if,
  inout  wire  [15:0]        Bus
);

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [7:0]  wlo_q, wlo_d;
  logic        c8_q, c8_d;
  logic [15:0] result_q, result_d;
  logic        carry_q, carry_d;

  logic [7:0]  add_a, add_b, add_sum;
  logic        add_ci, add_co;

  // One adder serves both bytes; the high step folds in the saved low-byte carry.
  always_comb begin
    if (state_q == StHi) begin
      add_a  = a_q[15:8];
      add_b  = b_q[15:8];
      add_ci = c8_q;
    end else begin
      add_a  = a_q[7:0];
      add_b  = b_q[7:0];
      add_ci = 1'b0;
    end
  end

  byte_adder u_byte_adder (
    .a_i   (add_a),
    .b_i   (add_b),
    .ci_i  (add_ci),
    .sum_o (add_sum),
    .co_o  (add_co)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    wlo_d    = wlo_q;
    c8_d     = c8_q;
    result_d = result_q;
    carry_d  = carry_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (!bus_if.start_n) begin
          a_d     = bus_if.Addr;
          b_d     = operand_b(bus_if.op, bus_if.MainBus);
          state_d = StLo;
        end
      end
      StLo: begin
        wlo_d   = add_sum;
        c8_d    = add_co;
        state_d = StHi;
      end
      StHi: begin
        result_d = {add_sum, wlo_q};
        carry_d  = add_co;
        state_d  = StDone;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      wlo_q    <= 8'h00;
      c8_q     <= 1'b0;
      result_q <= ResultRst;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wlo_q    <= wlo_d;
      c8_q     <= c8_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign bus_if.busy  = (state_q == StLo) || (state_q == StHi);
  assign bus_if.done  = (state_q == StDone);
  assign bus_if.carry = carry_q;

  assign Bus = bus_if.a_ta_xfer_n ? 16'hzzzz : result_q;

endmodule

// File: doc/xfer_offset_adder.md
# xfer_offset_adder

Two-cycle, byte-serial 16-bit address adder downstream of the transfer register. It captures the value the transfer register asserts on the address bus and adds +1, −1 or an 8-bit offset taken from the main bus. It holds the 16-bit result and drives it back onto the transfer bus on command, so the transfer register can reload it with its full-width transfer-bus load. The datapath is 8 bits wide per cycle, mirroring the 8-bit hardware adders.

## Interface
Parameters:
- none (widths fixed: 8-bit main bus, 16-bit address/transfer bus)

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst_n  input  1  reset; one clock, synchronous, active-low
- Addr  input  16  address bus; operand A source
- MainBus  input  8  main bus; offset source for ops 2/3
- Bus  inout  16  transfer bus; driven only while a_ta_xfer_n low, else high-Z
- start_n  input  1  active-low start strobe, sampled each rising edge
- op  input  2  operation, sampled with start_n: 0 = +1, 1 = −1, 2 = +signed MainBus, 3 = +unsigned MainBus
- a_ta_xfer_n  input  1  active-low: assert result onto Bus
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result register just updated
- carry  output  1  bit 16 of the 17-bit sum of the last completed operation

## Operation
- Operand B, formed at capture:
  - op0 → 0x0001
  - op1 → 0xFFFF
  - op2 → MainBus sign-extended to 16 bits
  - op3 → MainBus zero-extended to 16 bits
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if start_n low, capture A=Addr and B into operand regs, go to LO.
  - LO: wlo = A[7:0]+B[7:0]; save c8 (low-byte carry); go to HI.
  - HI: whi = A[15:8]+B[15:8]+c8. On this edge, copy {whi, wlo} into the result register and bit 16 into carry. Go to DONE.
  - DONE: done=1. If start_n low, capture new operands and go to LO (back-to-back). Else go to IDLE.
- start_n sampled in LO or HI is ignored. There is no queueing.
- The result register changes only on the HI edge. Bus never shows a partially computed value.
- Bus = a_ta_xfer_n ? 'z : result. The drive is combinational and independent of FSM state.
- All arithmetic is modulo 2^16. Wrap-around is silent except through carry.
- With op1, carry=1 means no borrow.
- With op2 and a negative offset, carry=1 means no borrow past 0x0000.
- Reset, from any state, including mid-operation:
  - state → IDLE
  - result=0x0000, carry=0, busy=0, done=0
  - operand, wlo and c8 registers cleared
  - any in-flight operation is discarded

## Timing
- start_n low at edge N:
  - edge N: operands captured
  - edge N+1: low byte computed
  - edge N+2: result and carry valid
  - done high from N+2 to N+3
- busy is high while in LO or HI, i.e. from edge N to N+2.
- Back-to-back: with start_n low in DONE, throughput is one result per 3 cycles.
- Addr, MainBus and op need only be valid at the capture edge.
- The Bus enable path is purely combinational from a_ta_xfer_n. Same-cycle drive.
- If rst_n is low at edge N with start_n low, reset wins. No capture occurs.

## Structure
- Package xfer_offset_pkg:
  - op encodings: OP_INC, OP_DEC, OP_ADD_S, OP_ADD_U
  - FSM state enum
  - result reset value 16'h0000
- Sub-module byte_adder: 8-bit a, 8-bit b, carry-in → 8-bit sum, carry-out. Instantiate it once and share it between the LO and HI states through operand muxes.
- Top level: FSM, operand and working registers, result register, tri-state Bus driver.

## Test plan
- Reset: hold rst_n low 2 cycles → result 0x0000, carry 0, busy 0, done 0, Bus high-Z with a_ta_xfer_n high.
- Inc wrap: Addr=0xFFFF, op0 → after 3 edges result 0xFFFF→0x0000, carry 1, done pulse exactly 1 cycle.
- Dec wrap: Addr=0x0000, op1 → result 0xFFFF, carry 0. Addr=0x1000, op1 → 0x0FFF, carry 1.
- Offsets, Addr=0x1234, MainBus=0x80:
  - op2 → 0x11B4, carry 1
  - op3 → 0x12B4, carry 0
  - Bus reads the value only while a_ta_xfer_n is low
- Ignore and back-to-back:
  - start_n pulsed in LO and HI → no extra result
  - start_n low in DONE with Addr=0x00FF, op0 → next result 0x0100 three cycles after the previous done
- Reset mid-op: assert rst_n in HI → result stays 0x0000, no done pulse, FSM in IDLE next cycle.
